// File: rtl/seq1001_gen_if.sv
// Handshake/data bundle between the stimulus controller and the seq1001_gen pattern generator.
interface seq1001_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [3:0]       rep;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;
  logic [7:0]       hit_cnt;

  modport master (
    output start, pattern, rep,
    input  x, valid, busy, done, hit_cnt
  );

  modport slave (
    input  start, pattern, rep,
    output x, valid, busy, done, hit_cnt
  );
endinterface

// File: rtl/seq1001_gen.sv
// Serial MSB-first pattern generator feeding the 1001 detector, with repeat count and handshake.
// Optional hit counter enabled by defining SEQ1001_GEN_SELFCHECK_EN.
module seq1001_gen #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  seq1001_gen_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]       rep_q, rep_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sr_d      = bus.pattern;
          rep_d     = bus.rep;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        // Rotate rather than shift so each repetition reuses the captured pattern.
        sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        if (bit_cnt_q == CntW'(WIDTH - 1)) begin
          bit_cnt_d = '0;
          if (rep_q == 4'd0) begin
            state_d = StDone;
          end else begin
            rep_d = rep_q - 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    valid_d = (state_d == StShift);
    x_d     = valid_d & sr_d[WIDTH-1];
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef SEQ1001_GEN_SELFCHECK_EN
  logic [2:0] hist_q, hist_d;
  logic [7:0] hit_q, hit_d;

  always_comb begin
    hist_d = hist_q;
    hit_d  = hit_q;
    if ((state_q == StIdle) && bus.start) begin
      hist_d = '0;
      hit_d  = '0;
    end else if (valid_q) begin
      // Overlap falls out naturally: the matching final 1 stays in the history.
      hist_d = {hist_q[1:0], x_q};
      if (({hist_q, x_q} == 4'b1001) && (hit_q != 8'hFF)) begin
        hit_d = hit_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      hit_q  <= '0;
    end else begin
      hist_q <= hist_d;
      hit_q  <= hit_d;
    end
  end

  assign bus.hit_cnt = hit_q;
`else
  assign bus.hit_cnt = '0;
`endif

endmodule
